// File: rtl/pwm_ramp_pkg.sv
// rtl/pwm_ramp_pkg.sv - shared types and sizing helpers for the duty-ramp scheduler
package pwm_ramp_pkg;

  localparam int PKG_WIDTH_PERIOD = 16;
  localparam int PKG_WIDTH_DUTY   = 16;
  localparam int PKG_WIDTH_DIV    = 8;

  typedef enum logic {ST_IDLE, ST_UPDATE} ramp_state_e;

  function automatic int ch_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [PKG_WIDTH_PERIOD-1:0] period;
    logic [PKG_WIDTH_PERIOD-1:0] shadow_period;
    logic [PKG_WIDTH_DUTY-1:0]   duty;
    logic [PKG_WIDTH_DUTY-1:0]   target;
    logic [PKG_WIDTH_DUTY-1:0]   step;
    logic [PKG_WIDTH_DIV-1:0]    div;
    logic [PKG_WIDTH_DIV-1:0]    div_cnt;
  } ch_ctx_t;

endpackage

// File: rtl/pwm_rr_arb.sv
// rtl/pwm_rr_arb.sv - round-robin pick of the first request at or after a pointer
module pwm_rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any_req
);

  int            k;
  logic [IW-1:0] kk;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    kk    = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      kk = IW'(k);
      if (!found && req[kk]) begin
        found     = 1'b1;
        grant[kk] = 1'b1;
        idx       = kk;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/pwm_ramp_sched.sv
// rtl/pwm_ramp_sched.sv - per-channel duty ramp scheduler with a shared round-robin update engine
// Optional irq/irq_clr ports when PWM_RAMP_IRQ_EN is defined.
module pwm_ramp_sched
  import pwm_ramp_pkg::*;
#(
  parameter int N_CHANNELS   = 4,
  parameter int WIDTH_PERIOD = PKG_WIDTH_PERIOD,
  parameter int WIDTH_DUTY   = PKG_WIDTH_DUTY,
  parameter int WIDTH_DIV    = PKG_WIDTH_DIV
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [ch_idx_w(N_CHANNELS)-1:0]    cfg_ch,
  input  logic [WIDTH_PERIOD-1:0]            cfg_period,
  input  logic [WIDTH_DUTY-1:0]              cfg_target,
  input  logic [WIDTH_DUTY-1:0]              cfg_step,
  input  logic [WIDTH_DIV-1:0]               cfg_div,
  output logic                               cfg_err,
  input  logic [N_CHANNELS-1:0]              period_end,
  output logic [N_CHANNELS*WIDTH_PERIOD-1:0] period_flat,
  output logic [N_CHANNELS*WIDTH_DUTY-1:0]   duty_flat,
  output logic [N_CHANNELS-1:0]              ramp_busy,
  output logic [N_CHANNELS-1:0]              ramp_done
`ifdef PWM_RAMP_IRQ_EN
  ,
  output logic                               irq,
  input  logic                               irq_clr
`endif
);

  localparam int IW = ch_idx_w(N_CHANNELS);
  localparam logic [IW:0]          N_CH_L   = (IW+1)'(N_CHANNELS);
  localparam logic [IW-1:0]        LAST_CH  = IW'(N_CHANNELS - 1);
  localparam logic [IW-1:0]        IDX_ONE  = IW'(1);
  localparam logic [WIDTH_DIV-1:0] DIV_ONE  = WIDTH_DIV'(1);

  ramp_state_e state, state_n;
  ch_ctx_t     ctx [N_CHANNELS];

  logic [N_CHANNELS-1:0] pend, pend_n, grant_oh_q, arb_grant;
  logic [IW-1:0]         ptr, grant_q, arb_idx;
  logic                  arb_any;

  logic                  cfg_fire, cfg_bad, ch_ok;
  logic [WIDTH_DUTY-1:0] cur_duty;

  ch_ctx_t               cur;
  logic [WIDTH_DIV-1:0]  eff_div, upd_div_cnt;
  logic [WIDTH_DUTY:0]   up_sum;
  logic [WIDTH_DUTY-1:0] upd_duty;
  logic                  take_step, upd_done, done_set;

  pwm_rr_arb #(.N(N_CHANNELS), .IW(IW)) u_arb (
    .req     (pend),
    .ptr     (ptr),
    .grant   (arb_grant),
    .idx     (arb_idx),
    .any_req (arb_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (arb_any) state_n = ST_UPDATE;
      ST_UPDATE: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  assign cfg_ready = (state == ST_IDLE);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign ch_ok     = {1'b0, cfg_ch} < N_CH_L;
  assign cur_duty  = ctx[cfg_ch].duty;
  assign cfg_bad   = !ch_ok || (cfg_target > cfg_period) ||
                     ((cfg_step == '0) && (cfg_target != cur_duty));

  // A wrap arriving on the same edge as the service of that channel must survive.
  always_comb begin
    pend_n = pend;
    if (state == ST_UPDATE) pend_n = pend_n & ~grant_oh_q;
    pend_n = pend_n | period_end;
  end

  always_comb begin
    cur         = ctx[grant_q];
    eff_div     = (cur.div == '0) ? DIV_ONE : cur.div;
    take_step   = (cur.div_cnt <= DIV_ONE);
    upd_div_cnt = take_step ? eff_div : (cur.div_cnt - DIV_ONE);
    up_sum      = {1'b0, cur.duty} + {1'b0, cur.step};
    upd_duty    = cur.duty;
    if (take_step) begin
      if (cur.target > cur.duty)
        upd_duty = (up_sum > {1'b0, cur.target}) ? cur.target : up_sum[WIDTH_DUTY-1:0];
      else if (cur.duty > cur.target)
        upd_duty = ((cur.duty - cur.target) < cur.step) ? cur.target : (cur.duty - cur.step);
    end
    upd_done = take_step && (cur.duty != cur.target) && (upd_duty == cur.target);
    done_set = (state == ST_UPDATE) && upd_done;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CHANNELS; i++) ctx[i] <= '0;
      pend       <= '0;
      ptr        <= '0;
      grant_q    <= '0;
      grant_oh_q <= '0;
      ramp_busy  <= '0;
      ramp_done  <= '0;
      cfg_err    <= 1'b0;
    end else begin
      pend      <= pend_n;
      ramp_done <= '0;
      cfg_err   <= 1'b0;
      // The grant is frozen on entry to UPDATE so late wraps cannot redirect it.
      if (state == ST_IDLE) begin
        grant_q    <= arb_idx;
        grant_oh_q <= arb_grant;
      end
      if (cfg_fire) begin
        if (cfg_bad) begin
          cfg_err <= 1'b1;
        end else begin
          ctx[cfg_ch].target        <= cfg_target;
          ctx[cfg_ch].step          <= cfg_step;
          ctx[cfg_ch].div           <= cfg_div;
          ctx[cfg_ch].div_cnt       <= cfg_div;
          ctx[cfg_ch].shadow_period <= cfg_period;
          ramp_busy[cfg_ch]         <= (cfg_target != cur_duty);
        end
      end
      if (state == ST_UPDATE) begin
        ptr                   <= (grant_q == LAST_CH) ? '0 : (grant_q + IDX_ONE);
        ctx[grant_q].period   <= ctx[grant_q].shadow_period;
        ctx[grant_q].div_cnt  <= upd_div_cnt;
        ctx[grant_q].duty     <= upd_duty;
        if (upd_done) begin
          ramp_busy[grant_q] <= 1'b0;
          ramp_done[grant_q] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    period_flat = '0;
    duty_flat   = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      period_flat[i*WIDTH_PERIOD +: WIDTH_PERIOD] = ctx[i].period;
      duty_flat[i*WIDTH_DUTY +: WIDTH_DUTY]       = ctx[i].duty;
    end
  end

`ifdef PWM_RAMP_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      irq <= 1'b0;
    else if (done_set) irq <= 1'b1;
    else if (irq_clr)  irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_pwm_ramp_sched.sv
// tb/tb_pwm_ramp_sched.sv - scoreboard bench for pwm_ramp_sched
module tb_pwm_ramp_sched;

  localparam int K_PER = 0, K_DUTY = 1, K_DONE = 2, K_ERR = 3;

  typedef struct {
    int kind;
    int ch;
    int val;
    int gap;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_period = '0;
  logic [15:0] cfg_target = '0;
  logic [15:0] cfg_step = '0;
  logic [7:0]  cfg_div = '0;
  logic        cfg_err;
  logic [3:0]  period_end = '0;
  logic [63:0] period_flat;
  logic [63:0] duty_flat;
  logic [3:0]  ramp_busy;
  logic [3:0]  ramp_done;
`ifdef PWM_RAMP_IRQ_EN
  logic        irq;
  logic        irq_clr = 1'b0;
`endif

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  last_cyc = 0;
  int  prev_per [4] = '{default: 0};
  int  prev_duty [4] = '{default: 0};
  ev_t exp_q [$];

  pwm_ramp_sched dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_target  (cfg_target),
    .cfg_step    (cfg_step),
    .cfg_div     (cfg_div),
    .cfg_err     (cfg_err),
    .period_end  (period_end),
    .period_flat (period_flat),
    .duty_flat   (duty_flat),
    .ramp_busy   (ramp_busy),
    .ramp_done   (ramp_done)
`ifdef PWM_RAMP_IRQ_EN
    ,
    .irq         (irq),
    .irq_clr     (irq_clr)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int kind, input int ch, input int val, input int gap);
    ev_t e;
    e.kind = kind; e.ch = ch; e.val = val; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic see(input int kind, input int ch, input int val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual kind=%0d ch=%0d val=%0h required=none", kind, ch, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.ch != ch || e.val != val) begin
        failures++;
        $display("FAIL event actual kind=%0d ch=%0d val=%0h required kind=%0d ch=%0d val=%0h",
                 kind, ch, val, e.kind, e.ch, e.val);
      end
      if (e.gap >= 0) begin
        checks++;
        if (cyc - last_cyc != e.gap) begin
          failures++;
          $display("FAIL event_gap ch=%0d actual=%0d required=%0d", ch, cyc - last_cyc, e.gap);
        end
      end
    end
    last_cyc = cyc;
  endtask

  // Monitor: every observable change becomes an event popped against the queue.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      int p, d;
      p = int'(period_flat[c*16 +: 16]);
      d = int'(duty_flat[c*16 +: 16]);
      if (p != prev_per[c]) see(K_PER, c, p);
      if (d != prev_duty[c]) see(K_DUTY, c, d);
      if (ramp_done[c]) see(K_DONE, c, 0);
      prev_per[c]  = p;
      prev_duty[c] = d;
    end
    if (cfg_err) see(K_ERR, 0, 0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input int per, input int tgt, input int stp, input int dv);
    int t = 0;
    cfg_ch = 2'(ch); cfg_period = 16'(per); cfg_target = 16'(tgt);
    cfg_step = 16'(stp); cfg_div = 8'(dv);
    while (!cfg_ready && t < 50) begin
      tick(1);
      t++;
    end
    checks++;
    if (t >= 50) begin
      failures++;
      $display("FAIL cfg_ready_timeout actual=0 required=1");
    end
    cfg_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] m, input int wait_n);
    period_end = m;
    tick(1);
    period_end = '0;
    tick(wait_n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Reset with a request held valid
    cfg_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_duty", int'(duty_flat != 0), 0);
    chk("rst_period", int'(period_flat != 0), 0);
    chk("rst_busy", int'(ramp_busy), 0);
    chk("rst_done", int'(ramp_done), 0);
    chk("rst_err", int'(cfg_err), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    reset_n = 1'b1;
    cfg_valid = 1'b0;
    tick(2);
    chk("post_rst_ready", int'(cfg_ready), 1);

    // Ramp up, ch0
    cfg(0, 100, 10, 4, 1);
    chk("up_busy", int'(ramp_busy[0]), 1);
    expect_ev(K_PER, 0, 100, -1);
    expect_ev(K_DUTY, 0, 4, 0);
    pulse(4'b0001, 7);
    expect_ev(K_DUTY, 0, 8, 8);
    pulse(4'b0001, 7);
    expect_ev(K_DUTY, 0, 10, 8);
    expect_ev(K_DONE, 0, 0, 0);
    pulse(4'b0001, 7);
    chk("up_busy_drop", int'(ramp_busy[0]), 0);

    // Ramp down with div=2, ch1
    cfg(1, 100, 10, 10, 1);
    expect_ev(K_PER, 1, 100, -1);
    expect_ev(K_DUTY, 1, 10, 0);
    expect_ev(K_DONE, 1, 0, 0);
    pulse(4'b0010, 7);
    cfg(1, 100, 0, 3, 2);
    chk("down_busy", int'(ramp_busy[1]), 1);
    pulse(4'b0010, 7);
    chk("down_hold", int'(duty_flat[31:16]), 10);
    expect_ev(K_DUTY, 1, 7, -1);
    expect_ev(K_DUTY, 1, 4, 16);
    expect_ev(K_DUTY, 1, 1, 16);
    expect_ev(K_DUTY, 1, 0, 16);
    expect_ev(K_DONE, 1, 0, 0);
    for (int i = 0; i < 7; i++) pulse(4'b0010, 7);

    // Contention with pointer at ch2; ch2 also exercises div=0
    cfg(0, 100, 20, 5, 1);
    cfg(1, 100, 5, 5, 1);
    cfg(2, 60, 7, 7, 0);
    cfg(3, 60, 3, 1, 1);
    expect_ev(K_PER, 2, 60, -1);
    expect_ev(K_DUTY, 2, 7, 0);
    expect_ev(K_DONE, 2, 0, 0);
    expect_ev(K_PER, 3, 60, 2);
    expect_ev(K_DUTY, 3, 1, 0);
    expect_ev(K_DUTY, 0, 15, 2);
    expect_ev(K_DUTY, 1, 5, 2);
    expect_ev(K_DONE, 1, 0, 0);
    pulse(4'b1111, 12);

    // Rejected requests leave ch0 untouched
    expect_ev(K_ERR, 0, 0, -1);
    cfg(0, 100, 200, 1, 1);
    tick(2);
    expect_ev(K_ERR, 0, 0, -1);
    cfg(0, 100, 50, 0, 1);
    tick(2);
    chk("rej_busy", int'(ramp_busy[0]), 1);
    expect_ev(K_DUTY, 0, 20, -1);
    expect_ev(K_DONE, 0, 0, 0);
    pulse(4'b0001, 7);

    // Saturation at the top of the duty range, ch3
    cfg(3, 16'hFFFF, 16'hFFF0, 16'hFFF0, 1);
    expect_ev(K_PER, 3, 16'hFFFF, -1);
    expect_ev(K_DUTY, 3, 16'hFFF0, 0);
    expect_ev(K_DONE, 3, 0, 0);
    pulse(4'b1000, 7);
    cfg(3, 16'hFFFF, 16'hFFFF, 16'h0100, 1);
    chk("ovf_busy", int'(ramp_busy[3]), 1);
    expect_ev(K_DUTY, 3, 16'hFFFF, -1);
    expect_ev(K_DONE, 3, 0, 0);
    pulse(4'b1000, 7);
    chk("ovf_busy_drop", int'(ramp_busy[3]), 0);
`ifdef PWM_RAMP_IRQ_EN
    chk("irq_set", int'(irq), 1);
    irq_clr = 1'b1;
    tick(1);
    irq_clr = 1'b0;
    chk("irq_clr", int'(irq), 0);
`endif

    // Async reset in the middle of a ramp
    cfg(0, 100, 40, 1, 1);
    expect_ev(K_DUTY, 0, 21, -1);
    pulse(4'b0001, 7);
    for (int c = 0; c < 4; c++) begin
      expect_ev(K_PER, c, 0, -1);
      expect_ev(K_DUTY, c, 0, -1);
    end
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("abort_busy", int'(ramp_busy), 0);
    chk("abort_duty0", int'(duty_flat[15:0]), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick(6);
    chk("abort_ready", int'(cfg_ready), 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
